// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) error checker with self-synchronising acquisition, windowed
// loss-of-lock detection and saturating bit/error counters.
module prbs_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int WIN_LEN   = 64,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] rx_sample,
  input  logic              rx_valid,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              cnt_sat,
  output logic              lock_lost
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WBITS_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WERRS_W = $clog2(LOSS_ERRS + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [6:0]         s_q,         s_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [WBITS_W-1:0] win_bits_q,  win_bits_d;
  logic [WERRS_W-1:0] win_errs_q,  win_errs_d;
  logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;
  logic               cnt_sat_q,   cnt_sat_d;
  logic               locked_q,    locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic               lock_lost_q, lock_lost_d;

  logic rx_bit;
  logic pred_bit;
  logic mismatch;
  logic bit_inc;
  logic err_inc;

  // Zero is sliced as a one: only the sign decides.
  assign rx_bit   = (rx_sample >= 8'sd0);
  assign pred_bit = s_q[6] ^ s_q[5];
  assign mismatch = rx_bit ^ pred_bit;

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch below can leave one unassigned (no latches).
    state_d     = state_q;
    s_d         = s_q;
    match_cnt_d = match_cnt_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    cnt_sat_d   = cnt_sat_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    bit_inc     = 1'b0;
    err_inc     = 1'b0;

    if (rx_valid) begin
      case (state_q)
        SEARCH: begin
          s_d = {s_q[5:0], rx_bit};
          // An all-zero history predicts zeros forever, so it never counts as a match.
          if (!mismatch && (s_q != 7'd0)) begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        LOCKED: begin
          s_d         = {s_q[5:0], pred_bit};
          bit_inc     = 1'b1;
          err_inc     = mismatch;
          err_pulse_d = mismatch;
          if (mismatch && (win_errs_q == WERRS_W'(LOSS_ERRS - 1))) begin
            state_d     = SEARCH;
            lock_lost_d = 1'b1;
            match_cnt_d = '0;
            win_bits_d  = '0;
            win_errs_d  = '0;
          end else if (win_bits_q == WBITS_W'(WIN_LEN - 1)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WBITS_W'(1);
            win_errs_d = win_errs_q + WERRS_W'(mismatch);
          end
        end

        default: state_d = SEARCH;
      endcase
    end

    // A clear coincident with a counted bit wins over the increment.
    if (clear_cnt) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
      cnt_sat_d = 1'b0;
    end else begin
      if (bit_inc && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
      cnt_sat_d = cnt_sat_q | (&bit_cnt_d) | (&err_cnt_d);
    end

    locked_d = (state_d == LOCKED);
  end

  // NOTE: reset is asynchronous and clears every flop; there is no memory here that could stay unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      s_q         <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      cnt_sat_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      s_q         <= s_d;
      match_cnt_q <= match_cnt_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cnt_sat_q   <= cnt_sat_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign bit_cnt   = bit_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign cnt_sat   = cnt_sat_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed PRBS7 streams into a default instance (a) and a
// narrow-counter instance (b); err_pulse/lock_lost events are checked by a scoreboard.
module tb_prbs_checker;

  logic              clk;
  logic              reset;
  logic              rx_valid;
  logic              clear_cnt;
  logic signed [7:0] rx_sample_a;
  logic signed [7:0] rx_sample_b;

  logic        a_locked, a_err_pulse, a_cnt_sat, a_lock_lost;
  logic [31:0] a_bit_cnt, a_err_cnt;
  logic        b_locked, b_err_pulse, b_cnt_sat, b_lock_lost;
  logic [3:0]  b_bit_cnt, b_err_cnt;

  typedef enum int {EV_ERR = 1, EV_LOSS = 2} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned err_cnt;
  } ev_t;

  ev_t               exp_q[$];
  int unsigned       tests = 0;
  int unsigned       fails = 0;
  logic [6:0]        tx_s;
  logic signed [7:0] lvl_hi;
  logic signed [7:0] lvl_lo;

  prbs_checker dut_a (
    .clk       (clk),
    .reset     (reset),
    .rx_sample (rx_sample_a),
    .rx_valid  (rx_valid),
    .clear_cnt (clear_cnt),
    .locked    (a_locked),
    .err_pulse (a_err_pulse),
    .bit_cnt   (a_bit_cnt),
    .err_cnt   (a_err_cnt),
    .cnt_sat   (a_cnt_sat),
    .lock_lost (a_lock_lost)
  );

  prbs_checker #(.CNT_W(4), .LOSS_ERRS(100)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .rx_sample (rx_sample_b),
    .rx_valid  (rx_valid),
    .clear_cnt (clear_cnt),
    .locked    (b_locked),
    .err_pulse (b_err_pulse),
    .bit_cnt   (b_bit_cnt),
    .err_cnt   (b_err_cnt),
    .cnt_sat   (b_cnt_sat),
    .lock_lost (b_lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Next PRBS7 bit when valid; on invalid cycles the wrong bit is driven as garbage.
  task automatic send(input logic inv_a, input logic inv_b, input logic valid, input logic clr);
    logic b;
    if (valid) begin
      b    = tx_s[6] ^ tx_s[5];
      tx_s = {tx_s[5:0], b};
    end else begin
      b = ~(tx_s[6] ^ tx_s[5]);
    end
    rx_sample_a = (b ^ inv_a) ? lvl_hi : lvl_lo;
    rx_sample_b = (b ^ inv_b) ? lvl_hi : lvl_lo;
    rx_valid    = valid;
    clear_cnt   = clr;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
  endtask

  task automatic send_raw(input logic signed [7:0] smp);
    rx_sample_a = smp;
    rx_sample_b = smp;
    rx_valid    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input ev_kind_e kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_unexpected: got event kind %0d, expected no event", kind);
    end else begin
      ev = exp_q.pop_front();
      check("sb_kind", kind, ev.kind);
      check("sb_err_cnt", a_err_cnt, ev.err_cnt);
      if (kind == EV_LOSS) check("sb_locked_after_loss", a_locked, 0);
    end
  endtask

  always @(negedge clk) begin
    if (a_err_pulse === 1'b1) pop_check(EV_ERR);
    if (a_lock_lost === 1'b1) pop_check(EV_LOSS);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned a_errs;
    logic        inv;
    logic        seen_lock;

    reset       = 1'b0;
    rx_valid    = 1'b0;
    clear_cnt   = 1'b0;
    rx_sample_a = '0;
    rx_sample_b = '0;
    tx_s        = 7'h7F;
    lvl_hi      = 8'sd64;
    lvl_lo      = -8'sd64;
    a_errs      = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_locked",    a_locked,    0);
    check("rst_err_pulse", a_err_pulse, 0);
    check("rst_bit_cnt",   a_bit_cnt,   0);
    check("rst_err_cnt",   a_err_cnt,   0);
    check("rst_cnt_sat",   a_cnt_sat,   0);
    check("rst_lock_lost", a_lock_lost, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Seed 7F emits six zeros (ignored while s==0), then lock after 7+16 bits.
    repeat (22) send(0, 0, 1, 0);
    check("lock_not_yet_a", a_locked, 0);
    check("lock_not_yet_b", b_locked, 0);
    send(0, 0, 1, 0);
    check("lock_at_23_a", a_locked, 1);
    check("lock_at_23_b", b_locked, 1);
    check("lock_bit_cnt", a_bit_cnt, 0);

    // Inversions at locked bits 100, 200, 300 (one per loss window).
    for (int n = 1; n <= 320; n++) begin
      inv = (n == 100) || (n == 200) || (n == 300);
      if (inv) begin
        a_errs++;
        exp_q.push_back('{kind: EV_ERR, err_cnt: a_errs});
      end
      send(inv, inv, 1, 0);
      if (n == 10) begin
        check("clean_bit_cnt_10", a_bit_cnt, 10);
        check("clean_err_cnt_10", a_err_cnt, 0);
      end
    end
    check("three_err_cnt",    a_err_cnt, 3);
    check("three_bit_cnt",    a_bit_cnt, 320);
    check("three_locked",     a_locked,  1);
    check("b_bit_cnt_sat",    b_bit_cnt, 15);
    check("b_cnt_sat_by_bit", b_cnt_sat, 1);
    check("b_err_cnt_three",  b_err_cnt, 3);

    send(0, 0, 1, 1);
    check("clr_bit_cnt_a", a_bit_cnt, 0);
    check("clr_err_cnt_a", a_err_cnt, 0);
    check("clr_locked_a",  a_locked,  1);
    check("clr_bit_cnt_b", b_bit_cnt, 0);
    check("clr_cnt_sat_b", b_cnt_sat, 0);

    // Eight consecutive inversions in one window: a loses lock on the 8th.
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back('{kind: EV_ERR, err_cnt: i});
      if (i == 8) exp_q.push_back('{kind: EV_LOSS, err_cnt: 8});
      send(1, 1, 1, 0);
    end
    check("loss_locked_a",  a_locked,  0);
    check("loss_err_cnt_a", a_err_cnt, 8);
    check("loss_bit_cnt_a", a_bit_cnt, 8);
    check("loss_locked_b",  b_locked,  1);
    // The free-running state survives the loss, so 16 clean bits re-acquire.
    repeat (15) send(0, 0, 1, 0);
    check("relock_not_yet", a_locked, 0);
    send(0, 0, 1, 0);
    check("relock_locked",  a_locked,  1);
    check("relock_err_cnt", a_err_cnt, 8);
    check("relock_bit_cnt", a_bit_cnt, 8);

    // Continuous errors into b only: err_cnt 8 -> sticks at 15.
    for (int i = 1; i <= 10; i++) begin
      send(0, 1, 1, 0);
      if (i == 7) check("b_err_cnt_reach_15", b_err_cnt, 15);
    end
    check("b_err_cnt_stuck",  b_err_cnt, 15);
    check("b_cnt_sat_set",    b_cnt_sat, 1);
    check("b_locked_no_loss", b_locked,  1);
    send(0, 0, 1, 1);
    check("b_clr_err_cnt", b_err_cnt, 0);
    check("b_clr_cnt_sat", b_cnt_sat, 0);

    // Asynchronous reset between clock edges.
    repeat (5) send(0, 0, 1, 0);
    check("pre_rst_bit_cnt", a_bit_cnt, 5);
    #2 reset = 1'b0;
    #1;
    check("async_rst_locked_a", a_locked,  0);
    check("async_rst_locked_b", b_locked,  0);
    check("async_rst_bit_cnt",  a_bit_cnt, 0);
    @(negedge clk) reset = 1'b1;

    // All-zero (most negative) input never locks.
    seen_lock = 1'b0;
    repeat (500) begin
      send_raw(-8'sd128);
      seen_lock = seen_lock | a_locked | b_locked;
    end
    check("zeros_never_lock", seen_lock, 0);

    // 50% valid with slicer boundary levels (0 -> one, -1 -> zero).
    tx_s   = 7'h7F;
    lvl_hi = 8'sd0;
    lvl_lo = -8'sd1;
    for (int v = 1; v <= 23; v++) begin
      send(0, 0, 1, 0);
      if (v == 22) check("toggle_not_yet", a_locked, 0);
      send(0, 0, 0, 0);
    end
    check("toggle_locked_a", a_locked,  1);
    check("toggle_locked_b", b_locked,  1);
    check("toggle_bit_cnt0", a_bit_cnt, 0);
    send(0, 0, 1, 0);
    check("toggle_bit_cnt1", a_bit_cnt, 1);
    send(0, 0, 0, 0);
    check("invalid_hold_bit_cnt", a_bit_cnt,   1);
    check("invalid_no_pulse",     a_err_pulse, 0);
    send(0, 0, 1, 0);
    check("toggle_bit_cnt2", a_bit_cnt, 2);
    check("toggle_err_cnt",  a_err_cnt, 0);

    repeat (2) send(0, 0, 1, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
